// File: rtl/hit_event_sequencer.sv
// Hit FIFO and event framer feeding the hit storage stage.
// Optional SSID_FILTER_EN drops hits whose SSID exceeds MAXSSID.
module hit_event_sequencer #(
  parameter int SSIDBITS    = 12,
  parameter int HITINFOBITS = 8,
  parameter int FIFODEPTH   = 16,
  parameter int MAXHITS     = 255,
  parameter int COUNTBITS   = 8,
  parameter int DRAINCYCLES = 4,
  parameter int MAXSSID     = 4095
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [SSIDBITS-1:0]    inSSID,
  input  logic [HITINFOBITS-1:0] inHitInfo,
  input  logic                   inEndEvent,
  input  logic                   storageReady,
  output logic                   newAddress,
  output logic [SSIDBITS-1:0]    SSID,
  output logic [HITINFOBITS-1:0] hitInfo,
  output logic                   clearMemory,
  output logic                   readMemory,
  input  logic                   readDone,
  output logic [COUNTBITS-1:0]   eventHitCount,
  output logic                   eventOverflow,
  output logic [COUNTBITS-1:0]   droppedCount
);

  localparam int PTRBITS   = $clog2(FIFODEPTH);
  localparam int CNTBITS   = PTRBITS + 1;
  localparam int DRAINBITS = $clog2(DRAINCYCLES + 1);
  localparam int CMPBITS   = SSIDBITS + 1;

`ifdef SSID_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {
    CLEAR,
    CLEARWAIT1,
    CLEARWAIT,
    STREAM,
    DRAIN,
    READOUT
  } stateT;

  typedef struct packed {
    logic                   endEvent;
    logic [SSIDBITS-1:0]    ssid;
    logic [HITINFOBITS-1:0] info;
  } entryT;

  entryT                mem [FIFODEPTH];
  logic [PTRBITS-1:0]   wrPtr;
  logic [PTRBITS-1:0]   rdPtr;
  logic [CNTBITS-1:0]   fifoCount;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 push;
  logic                 pop;
  entryT                popEntry;
  stateT                state;
  stateT                nextState;
  logic [DRAINBITS-1:0] drainCnt;
  logic                 ssidIllegal;
  logic                 filtered;
  logic                 atLimit;
  logic                 forward;

  assign fifoFull  = fifoCount == CNTBITS'(FIFODEPTH);
  assign fifoEmpty = fifoCount == '0;
  assign inReady   = resetN && !fifoFull;
  assign push      = inValid && inReady;
  assign popEntry  = mem[rdPtr];
  assign pop       = (state == STREAM) && storageReady && !fifoEmpty;

  assign ssidIllegal = {1'b0, popEntry.ssid} > CMPBITS'(MAXSSID);
  assign filtered    = FILTER && ssidIllegal;
  assign atLimit     = eventHitCount >= COUNTBITS'(MAXHITS);
  assign forward     = pop && !filtered && !atLimit;

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= {inEndEvent, inSSID, inHitInfo};
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      CLEAR:      nextState = CLEARWAIT1;
      CLEARWAIT1: nextState = CLEARWAIT;
      CLEARWAIT:  if (storageReady) nextState = STREAM;
      STREAM:     if (pop && popEntry.endEvent) nextState = DRAIN;
      DRAIN:      if (drainCnt == '0) nextState = READOUT;
      READOUT:    if (readDone) nextState = CLEAR;
      default:    nextState = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state         <= CLEAR;
      drainCnt      <= '0;
      newAddress    <= 1'b0;
      SSID          <= '0;
      hitInfo       <= '0;
      clearMemory   <= 1'b0;
      readMemory    <= 1'b0;
      eventHitCount <= '0;
      eventOverflow <= 1'b0;
      droppedCount  <= '0;
    end else begin
      state       <= nextState;
      newAddress  <= forward;
      clearMemory <= state == CLEAR;
      readMemory  <= nextState == READOUT;
      if (forward) begin
        SSID          <= popEntry.ssid;
        hitInfo       <= popEntry.info;
        eventHitCount <= eventHitCount + 1'b1;
      end
      // filtered hits count as dropped but are not an overflow
      if (pop && !forward) begin
        if (!filtered) eventOverflow <= 1'b1;
        if (droppedCount != '1) droppedCount <= droppedCount + 1'b1;
      end
      if (state == CLEARWAIT && storageReady) begin
        eventHitCount <= '0;
        droppedCount  <= '0;
        eventOverflow <= 1'b0;
      end
      if (state == STREAM)
        drainCnt <= DRAINBITS'(DRAINCYCLES - 1);
      else if (state == DRAIN && drainCnt != '0)
        drainCnt <= drainCnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hit_event_sequencer.sv
// Directed bench for hit_event_sequencer (MAXHITS=4, MAXSSID=0x0FF).
// Table of event vectors plus hand-written timing sequences.
module tb_hit_event_sequencer;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [11:0] inSSID = '0;
  logic [7:0]  inHitInfo = '0;
  logic        inEndEvent = 1'b0;
  logic        storageReady = 1'b1;
  logic        newAddress;
  logic [11:0] SSID;
  logic [7:0]  hitInfo;
  logic        clearMemory;
  logic        readMemory;
  logic        readDone = 1'b0;
  logic [7:0]  eventHitCount;
  logic        eventOverflow;
  logic [7:0]  droppedCount;

  int compared = 0;
  int mismatched = 0;
  int clearCount = 0;
  bit autoReadout = 1'b0;
  logic [19:0] outQ [$];
  int base;
  int idx;
  int c;
  int c0;

  typedef struct {
    int          nHits;
    logic [11:0] ssidBase;
    int          expFwd;
    int          expDrop;
    int          expOvf;
  } vecT;

  vecT vecs [5];

  always #5 clock = ~clock;

  hit_event_sequencer #(
    .SSIDBITS(12),
    .HITINFOBITS(8),
    .FIFODEPTH(16),
    .MAXHITS(4),
    .COUNTBITS(8),
    .DRAINCYCLES(4),
    .MAXSSID(12'h0FF)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .inValid(inValid),
    .inReady(inReady),
    .inSSID(inSSID),
    .inHitInfo(inHitInfo),
    .inEndEvent(inEndEvent),
    .storageReady(storageReady),
    .newAddress(newAddress),
    .SSID(SSID),
    .hitInfo(hitInfo),
    .clearMemory(clearMemory),
    .readMemory(readMemory),
    .readDone(readDone),
    .eventHitCount(eventHitCount),
    .eventOverflow(eventOverflow),
    .droppedCount(droppedCount)
  );

  always @(posedge clock) begin
    if (newAddress) outQ.push_back({SSID, hitInfo});
    if (clearMemory) clearCount <= clearCount + 1;
  end

  // readout side: one-cycle readDone once readMemory is seen
  always @(negedge clock)
    readDone <= autoReadout && readMemory && !readDone;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushHit(input logic [11:0] s, input logic [7:0] h,
                         input logic e);
    bit ok;
    int n;
    n = 0;
    inValid = 1'b1;
    inSSID = s;
    inHitInfo = h;
    inEndEvent = e;
    do begin
      ok = inReady;
      @(negedge clock);
      n++;
    end while (!ok && n < 300);
    check("push_accept", int'(ok), 1);
  endtask

  task automatic waitReadMemory(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!readMemory && n < 200);
    check({tag, "_readMemory"}, int'(readMemory), 1);
  endtask

  initial begin
    vecs[0] = '{1, 12'h030, 1, 0, 0};
    vecs[1] = '{4, 12'h040, 4, 0, 0};
    vecs[2] = '{5, 12'h050, 4, 1, 1};
    vecs[3] = '{6, 12'h060, 4, 2, 1};
    vecs[4] = '{3, 12'h070, 3, 0, 0};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_newAddress", int'(newAddress), 0);
    check("rst_clearMemory", int'(clearMemory), 0);
    check("rst_readMemory", int'(readMemory), 0);
    check("rst_eventHitCount", int'(eventHitCount), 0);
    check("rst_droppedCount", int'(droppedCount), 0);
    check("rst_eventOverflow", int'(eventOverflow), 0);
    check("rst_inReady", int'(inReady), 0);
    resetN = 1'b1;
    #1;
    check("rel_inReady", int'(inReady), 1);
    @(negedge clock);
    check("clear_after_reset", int'(clearMemory), 1);
    @(negedge clock);
    check("clear_single", int'(clearMemory), 0);
    @(negedge clock);

    // three-hit event with exact timing
    pushHit(12'h010, 8'hA1, 1'b0);
    check("lat_no_addr_yet", int'(newAddress), 0);
    pushHit(12'h011, 8'hA2, 1'b0);
    check("hit0_strobe", int'(newAddress), 1);
    check("hit0_ssid", int'(SSID), 'h010);
    check("hit0_info", int'(hitInfo), 'hA1);
    pushHit(12'h010, 8'hA3, 1'b1);
    inValid = 1'b0;
    check("hit1_strobe", int'(newAddress), 1);
    check("hit1_ssid", int'(SSID), 'h011);
    @(negedge clock);
    check("hit2_strobe", int'(newAddress), 1);
    check("hit2_ssid", int'(SSID), 'h010);
    check("hit2_info", int'(hitInfo), 'hA3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("drain%0d_addr", i), int'(newAddress), 0);
      check($sformatf("drain%0d_readMemory", i), int'(readMemory),
            (i == 3) ? 1 : 0);
    end
    check("ev1_hitCount", int'(eventHitCount), 3);
    check("ev1_overflow", int'(eventOverflow), 0);

    // next event queued during readout, held across the clear
    pushHit(12'h020, 8'hB1, 1'b0);
    pushHit(12'h021, 8'hB2, 1'b1);
    inValid = 1'b0;
    check("readout_held", int'(readMemory), 1);
    check("readout_no_addr", int'(newAddress), 0);
    base = outQ.size();
    storageReady = 1'b0;
    autoReadout = 1'b1;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!clearMemory && c < 10);
    check("clear_pulse", int'(clearMemory), 1);
    check("readMemory_dropped", int'(readMemory), 0);
    @(negedge clock);
    check("clear_one_cycle", int'(clearMemory), 0);
    repeat (4) @(negedge clock);
    check("no_addr_while_clearing", outQ.size() - base, 0);
    storageReady = 1'b1;
    c = 0;
    while (outQ.size() - base < 2 && c < 20) begin
      @(negedge clock);
      c++;
    end
    check("ev2_count", outQ.size() - base, 2);
    if (outQ.size() - base >= 2) begin
      check("ev2_hit0", int'(outQ[base]), {12'h020, 8'hB1});
      check("ev2_hit1", int'(outQ[base+1]), {12'h021, 8'hB2});
    end
    waitReadMemory("ev2");
    check("ev2_hitCount", int'(eventHitCount), 2);

    // table of events: forwarding, MAXHITS overflow, counter restart
    for (int v = 0; v < 5; v++) begin
      base = outQ.size();
      for (int h = 0; h < vecs[v].nHits; h++)
        pushHit(vecs[v].ssidBase + 12'(h), 8'(h),
                (h == vecs[v].nHits - 1) ? 1'b1 : 1'b0);
      inValid = 1'b0;
      waitReadMemory($sformatf("vec%0d", v));
      check($sformatf("vec%0d_hitCount", v), int'(eventHitCount),
            vecs[v].expFwd);
      check($sformatf("vec%0d_dropped", v), int'(droppedCount),
            vecs[v].expDrop);
      check($sformatf("vec%0d_overflow", v), int'(eventOverflow),
            vecs[v].expOvf);
      check($sformatf("vec%0d_pulses", v), outQ.size() - base,
            vecs[v].expFwd);
      for (int k = 0; k < vecs[v].expFwd && base + k < outQ.size(); k++)
        check($sformatf("vec%0d_hit%0d", v, k), int'(outQ[base+k]),
              {vecs[v].ssidBase + 12'(k), 8'(k)});
    end

    // fill the FIFO while storage is stalled, then drain 20 hits
    storageReady = 1'b0;
    base = outQ.size();
    idx = 0;
    for (int cyc = 0; cyc < 30 && idx < 20; cyc++) begin
      bit ok;
      inValid = 1'b1;
      inSSID = 12'h080 + 12'(idx);
      inHitInfo = 8'(idx);
      inEndEvent = (idx % 4 == 3);
      ok = inReady;
      @(negedge clock);
      if (ok) idx++;
    end
    check("fill_accepted", idx, 16);
    check("full_inReady", int'(inReady), 0);
    check("full_no_pop", outQ.size() - base, 0);
    storageReady = 1'b1;
    for (int cyc = 0; cyc < 300 && idx < 20; cyc++) begin
      bit ok;
      inValid = 1'b1;
      inSSID = 12'h080 + 12'(idx);
      inHitInfo = 8'(idx);
      inEndEvent = (idx % 4 == 3);
      ok = inReady;
      @(negedge clock);
      if (ok) idx++;
    end
    inValid = 1'b0;
    check("refill_accepted", idx, 20);
    c = 0;
    while (outQ.size() - base < 20 && c < 500) begin
      @(negedge clock);
      c++;
    end
    check("full_delivered", outQ.size() - base, 20);
    for (int k = 0; k < 20 && base + k < outQ.size(); k++)
      check($sformatf("full_hit%0d", k), int'(outQ[base+k]),
            {12'h080 + 12'(k), 8'(k)});
    waitReadMemory("full_last");
    check("full_last_hitCount", int'(eventHitCount), 4);
    check("full_last_overflow", int'(eventOverflow), 0);

`ifdef SSID_FILTER_EN
    base = outQ.size();
    pushHit(12'h050, 8'hC1, 1'b0);
    pushHit(12'h300, 8'hC2, 1'b0);
    pushHit(12'h0A0, 8'hC3, 1'b1);
    inValid = 1'b0;
    waitReadMemory("filt");
    check("filt_pulses", outQ.size() - base, 2);
    check("filt_dropped", int'(droppedCount), 1);
    check("filt_overflow", int'(eventOverflow), 0);
    check("filt_hitCount", int'(eventHitCount), 2);
`endif

    // reset mid-event discards queued hits
    storageReady = 1'b0;
    pushHit(12'h0C0, 8'h01, 1'b0);
    pushHit(12'h0C1, 8'h02, 1'b0);
    pushHit(12'h0C2, 8'h03, 1'b0);
    inValid = 1'b0;
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_inReady", int'(inReady), 0);
    check("midrst_readMemory", int'(readMemory), 0);
    resetN = 1'b1;
    storageReady = 1'b1;
    base = outQ.size();
    c0 = clearCount;
    repeat (15) @(negedge clock);
    check("midrst_flushed", outQ.size() - base, 0);
    check("midrst_one_clear", clearCount - c0, 1);
    check("midrst_hitCount", int'(eventHitCount), 0);
    check("midrst_inReady_back", int'(inReady), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
